// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: frame-synchronous pattern mode stepper (button / auto-advance);
// define PATTERN_SEQ_SWEEP_EN to sweep the band split column once per frame.
module vga_pattern_sequencer #(
  parameter int H_ACTIVE        = 640,
  parameter int NUM_MODES       = 4,
  parameter int FRAMES_PER_STEP = 120,
  parameter int SWEEP_STEP      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [10:0] i_x,
  input  logic [9:0]  i_y,
  input  logic        i_btn_next,
  input  logic        i_auto_en,
  output logic [1:0]  o_mode,
  output logic [10:0] o_split_x,
  output logic        o_frame_start
);
  typedef enum logic {S_SYNC, S_RUN} state_t;
  localparam logic [10:0] SPLIT_RST = 11'(H_ACTIVE / 4);
  state_t      state_q, state_d;
  logic        org_q, btn_q, pending_q, pending_d, fs_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic        origin, fe, be, run, man, auto_due, adv;
  always_comb begin
    origin    = i_x == 11'd0 && i_y == 10'd0;
    fe        = origin && !org_q;
    be        = i_btn_next && !btn_q;
    run       = state_q == S_RUN;
    man       = pending_q || be;
    auto_due  = i_auto_en && cnt_q == 8'(FRAMES_PER_STEP - 1);
    adv       = run && fe && (man || auto_due);
    state_d   = fe ? S_RUN : state_q;
    pending_d = (!run || fe) ? 1'b0 : pending_q || be;
    cnt_d     = !run ? 8'd0 : !fe ? cnt_q : (man || auto_due) ? 8'd0 : i_auto_en ? cnt_q + 8'd1 : cnt_q;
    mode_d    = !adv ? mode_q : (mode_q == 2'(NUM_MODES - 1)) ? 2'd0 : mode_q + 2'd1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_SYNC;
      org_q     <= 1'b0;
      btn_q     <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= 8'd0;
      mode_q    <= 2'd0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      org_q     <= origin;
      btn_q     <= i_btn_next;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      fs_q      <= fe;
    end
  end
`ifdef PATTERN_SEQ_SWEEP_EN
  logic [10:0] split_q, split_d;
  logic [11:0] sum;
  always_comb begin
    sum     = {1'b0, split_q} + 12'(SWEEP_STEP);
    split_d = !(run && fe) ? split_q : adv ? SPLIT_RST :
              (sum >= 12'(H_ACTIVE)) ? 11'(sum - 12'(H_ACTIVE)) : sum[10:0];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) split_q <= SPLIT_RST;
    else split_q <= split_d;
  end
  assign o_split_x = split_q;
`else
  assign o_split_x = SPLIT_RST;
`endif
  assign o_mode        = mode_q;
  assign o_frame_start = fs_q;
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb_vga_pattern_sequencer: directed + random stimulus against a frame-level reference model.
module tb_vga_pattern_sequencer;
  localparam int H = 640, NM = 4, FPS = 3, STEP = 4;
  logic        clk = 0, rst = 1;
  logic [10:0] i_x = 11'd5;
  logic [9:0]  i_y = 10'd3;
  logic        btn = 0, auto_en = 0;
  logic [1:0]  o_mode;
  logic [10:0] o_split_x;
  logic        o_frame_start;
  int n_checks = 0, n_fail = 0;
  int m_mode, m_split, m_cnt;
  bit m_synced, m_pend, m_prev_org, m_prev_btn, m_fs;
  vga_pattern_sequencer #(.H_ACTIVE(H), .NUM_MODES(NM), .FRAMES_PER_STEP(FPS), .SWEEP_STEP(STEP)) dut (
    .i_clk(clk), .i_rst(rst), .i_x(i_x), .i_y(i_y), .i_btn_next(btn), .i_auto_en(auto_en),
    .o_mode(o_mode), .o_split_x(o_split_x), .o_frame_start(o_frame_start));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input bit r, input bit origin, input bit b, input bit a);
    bit fe, be, adv;
    if (r) begin
      m_prev_org = 0; m_prev_btn = 0; m_synced = 0; m_pend = 0;
      m_cnt = 0; m_mode = 0; m_split = H / 4; m_fs = 0;
      return;
    end
    fe = origin && !m_prev_org;
    be = b && !m_prev_btn;
    m_fs = fe;
    if (!m_synced) begin
      m_synced = fe; m_pend = 0; m_cnt = 0;
    end else if (fe) begin
      adv = 0;
      if (m_pend || be) begin adv = 1; m_cnt = 0; end
      else if (a) begin
        m_cnt++;
        if (m_cnt == FPS) begin adv = 1; m_cnt = 0; end
      end
      m_pend = 0;
      if (adv) begin m_mode = (m_mode + 1) % NM; m_split = H / 4; end
`ifdef PATTERN_SEQ_SWEEP_EN
      else m_split = (m_split + STEP) % H;
`endif
    end else if (be) m_pend = 1;
    m_prev_org = origin;
    m_prev_btn = b;
  endtask
  task automatic step(input int x, input int y, input bit b, input bit a, input bit r);
    i_x = 11'(x); i_y = 10'(y); btn = b; auto_en = a; rst = r;
    @(posedge clk);
    model(r, x == 0 && y == 0, b, a);
    #1;
    chk("mode", o_mode, m_mode);
    chk("split", o_split_x, m_split);
    chk("frame_start", o_frame_start, m_fs);
  endtask
  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) step(5, 3, 0, a, 0);
  endtask
  task automatic press_fe();
    step(5, 3, 1, 0, 0); step(5, 3, 0, 0, 0); step(0, 0, 0, 0, 0); idle(2, 0);
  endtask
  initial begin
    int pulses;
    step(5, 3, 0, 0, 1); step(5, 3, 0, 0, 1);
    chk("rst_mode", o_mode, 0); chk("rst_split", o_split_x, 160); chk("rst_fs", o_frame_start, 0);
    step(5, 3, 1, 0, 0); step(5, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("sync_fs", o_frame_start, 1); chk("sync_no_adv", o_mode, 0);
    idle(2, 0);
    press_fe();
    chk("manual_adv", o_mode, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin step(0, 0, 0, 0, 0); pulses += int'(o_frame_start); end
    chk("hold_origin_pulses", pulses, 1);
    idle(2, 0);
    for (int i = 0; i < 3; i++) begin step(5, 3, 1, 0, 0); step(5, 3, 0, 0, 0); end
    step(0, 0, 0, 0, 0);
    chk("multi_be_once", o_mode, 2);
    idle(2, 0);
    step(0, 0, 1, 0, 0);
    chk("be_at_fe", o_mode, 3);
    step(5, 3, 0, 1, 0); idle(2, 1);
    for (int f = 1; f <= 3; f++) begin
      step(0, 0, 0, 1, 0); idle(2, 1);
      if (f == 2) chk("auto_hold", o_mode, 3);
    end
    chk("auto_wrap", o_mode, 0);
    for (int f = 1; f <= 3; f++) begin step(0, 0, 0, 1, 0); idle(2, 1); end
    chk("auto_step", o_mode, 1);
    idle(1, 0);
`ifdef PATTERN_SEQ_SWEEP_EN
    for (int f = 0; f < 200 && m_split != 636; f++) begin step(0, 0, 0, 0, 0); idle(1, 0); end
    chk("sweep_pre", o_split_x, 636);
    step(0, 0, 0, 0, 0);
    chk("sweep_wrap", o_split_x, 0);
    idle(1, 0);
    press_fe();
    chk("sweep_adv_reset", o_split_x, 160);
`else
    step(0, 0, 0, 0, 0);
    chk("split_const", o_split_x, 160);
    idle(1, 0);
`endif
    while (m_mode != 2) press_fe();
    chk("pre_rst_mode", o_mode, 2);
    step(5, 3, 0, 0, 1);
    chk("midrst_mode", o_mode, 0); chk("midrst_split", o_split_x, 160);
    press_fe();
    chk("resync_no_adv", o_mode, 0);
    step(0, 0, 0, 0, 0); idle(1, 0);
    chk("pending_discarded", o_mode, 0);
    for (int i = 0; i < 4000; i++) begin
      bit at_org, b, a, r;
      at_org = $urandom_range(0, 5) == 0;
      b = ($urandom_range(0, 7) == 0) ? ~btn : btn;
      a = ($urandom_range(0, 30) == 0) ? ~auto_en : auto_en;
      r = $urandom_range(0, 600) == 0;
      if (at_org) step(0, 0, b, a, r);
      else step($urandom_range(0, 12), $urandom_range(0, 2), b, a, r);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
